// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin access sequencer for a 4096x4 asynchronous SRAM
// Two requesters share the RAM; each access runs IDLE -> SETUP -> STROBE -> HOLD from latched copies.
module ram_arbiter #(
  parameter int STROBE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        notReset,
  input  logic        req0,
  input  logic        we0,
  input  logic [11:0] address0,
  input  logic [3:0]  writeData0,
  output logic [3:0]  readData0,
  output logic        ack0,
  input  logic        req1,
  input  logic        we1,
  input  logic [11:0] address1,
  input  logic [3:0]  writeData1,
  output logic [3:0]  readData1,
  output logic        ack1,
  output logic [11:0] ramAddress,
  output logic        ramNotChipEnable,
  output logic        ramNotWriteEnable,
  inout  wire  [3:0]  ramData,
  output logic        busy,
  output logic        grant
);

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("ram_arbiter: STROBE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [3:0]  wdata_q, wdata_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        nce_q, nce_d;
  logic        nwe_q, nwe_d;
  logic        drive_q, drive_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [3:0]  rdata0_q, rdata0_d;
  logic [3:0]  rdata1_q, rdata1_d;
  logic        pick_1;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    nce_d        = 1'b1;
    nwe_d        = 1'b1;
    drive_d      = drive_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    // On a tie the port that did not win last time is served.
    pick_1       = req1 && (!req0 || !last_grant_q);

    unique case (state_q)
      IDLE: begin
        drive_d = 1'b0;
        if (req0 || req1) begin
          grant_d      = pick_1;
          last_grant_d = pick_1;
          we_d         = pick_1 ? we1 : we0;
          addr_d       = pick_1 ? address1 : address0;
          wdata_d      = pick_1 ? writeData1 : writeData0;
          drive_d      = pick_1 ? we1 : we0;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
        count_d = STROBE_LOAD;
        nce_d   = 1'b0;
        nwe_d   = !we_q;
      end
      STROBE: begin
        if (count_q == 4'd0) begin
          state_d = HOLD;
          ack0_d  = !grant_q;
          ack1_d  = grant_q;
          if (!we_q) begin
            if (grant_q) rdata1_d = ramData;
            else         rdata0_d = ramData;
          end
        end else begin
          count_d = count_q - 4'd1;
          nce_d   = 1'b0;
          nwe_d   = !we_q;
        end
      end
      HOLD: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q      <= IDLE;
      count_q      <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 12'd0;
      wdata_q      <= 4'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      nce_q        <= 1'b1;
      nwe_q        <= 1'b1;
      drive_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= 4'd0;
      rdata1_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      nce_q        <= nce_d;
      nwe_q        <= nwe_d;
      drive_q      <= drive_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // The latched address doubles as the RAM address register.
  assign ramAddress        = addr_q;
  assign ramNotChipEnable  = nce_q;
  assign ramNotWriteEnable = nwe_q;
  assign ramData           = drive_q ? wdata_q : 4'bz;
  assign readData0         = rdata0_q;
  assign readData1         = rdata1_q;
  assign ack0              = ack0_q;
  assign ack1              = ack1_q;
  assign busy              = (state_q != IDLE);
  assign grant             = grant_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - bench for ram_arbiter at STROBE_CYCLES 2, 1 and 15
// Each instance talks to its own behavioural SRAM; a transaction-level model predicts grants, latency and data.
module tb_ram_arbiter;

  localparam int SC_TAB [3] = '{2, 1, 15};

  typedef struct {
    int          inst;
    logic        r0, w0;
    logic [11:0] a0;
    logic [3:0]  d0;
    logic        r1, w1;
    logic [11:0] a1;
    logic [3:0]  d1;
    int          exp_first;
    int          e0, e1;
  } vec_t;

  logic clock = 1'b0;
  logic notReset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic        req0 [3], we0 [3], req1 [3], we1 [3];
  logic [11:0] a0 [3], a1 [3];
  logic [3:0]  wd0 [3], wd1 [3], rd0 [3], rd1 [3];
  logic        ack0 [3], ack1 [3], nce [3], nwe [3], busy [3], grant [3];
  logic [11:0] ram_addr [3];
  logic [3:0]  bus_obs [3], sram_out [3];

  logic [3:0] ref_mem [3][4096];
  bit         ref_valid [3][4096];
  bit         last_g [3];
  logic [3:0] exp_rd [3][2];
  bit         exp_known [3][2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wire  [3:0] ram_data;
    logic [3:0] mem [4096];

    ram_arbiter #(.STROBE_CYCLES(SC_TAB[g])) u_dut (
      .clock(clock), .notReset(notReset),
      .req0(req0[g]), .we0(we0[g]), .address0(a0[g]), .writeData0(wd0[g]),
      .readData0(rd0[g]), .ack0(ack0[g]),
      .req1(req1[g]), .we1(we1[g]), .address1(a1[g]), .writeData1(wd1[g]),
      .readData1(rd1[g]), .ack1(ack1[g]),
      .ramAddress(ram_addr[g]), .ramNotChipEnable(nce[g]), .ramNotWriteEnable(nwe[g]),
      .ramData(ram_data), .busy(busy[g]), .grant(grant[g])
    );

    assign sram_out[g] = mem[ram_addr[g]];
    assign ram_data    = (!nce[g] && nwe[g]) ? sram_out[g] : 4'bz;
    assign bus_obs[g]  = ram_data;

    initial begin
      for (int j = 0; j < 4096; j++) mem[j] = 4'h0;
      forever begin
        @(negedge clock);
        if (notReset && !nce[g] && !nwe[g]) mem[ram_addr[g]] = ram_data;
      end
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(input int inst, input bit r0, input bit w0, input int ad0, input int dd0,
                              input bit r1, input bit w1, input int ad1, input int dd1,
                              input int f, input int e0, input int e1);
    vec_t v;
    v.inst = inst; v.r0 = r0; v.w0 = w0; v.a0 = 12'(ad0); v.d0 = 4'(dd0);
    v.r1 = r1; v.w1 = w1; v.a1 = 12'(ad1); v.d1 = 4'(dd1);
    v.exp_first = f; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 12'h000;
      1: return 12'hFFF;
      2: return 12'h123;
      3: return 12'h800;
      default: return 12'($urandom_range(0, 7));
    endcase
  endfunction

  // Bus invariants, chip-enable width and single-cycle acks, every cycle on every instance.
  initial begin
    logic        prev_nce [3];
    logic [11:0] prev_addr [3];
    logic        prev_ack [3][2];
    int          low_run [3];
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (!notReset) begin
          low_run[i] = 0; prev_nce[i] = 1'b1; prev_ack[i][0] = 1'b0; prev_ack[i][1] = 1'b0;
        end else begin
          if (!nwe[i]) chk("nwe_implies_nce", nce[i], 0);
          if (!nce[i] && !prev_nce[i]) chk("addr_stable_in_strobe", ram_addr[i], prev_addr[i]);
          if (!nce[i] && nwe[i]) chk("bus_undriven_read_strobe", bus_obs[i], sram_out[i]);
          if (!nce[i]) low_run[i]++;
          else if (low_run[i] > 0) begin
            chk("ce_low_cycles", low_run[i], SC_TAB[i]);
            low_run[i] = 0;
          end
          if (ack0[i]) chk("ack0_single_cycle", prev_ack[i][0], 0);
          if (ack1[i]) chk("ack1_single_cycle", prev_ack[i][1], 0);
          prev_nce[i] = nce[i]; prev_addr[i] = ram_addr[i];
          prev_ack[i][0] = ack0[i]; prev_ack[i][1] = ack1[i];
        end
      end
    end
  end

  // One round: the requested ports raise req together and each drops it at its ack.
  task automatic do_round(input vec_t v, input int mid_addr);
    int i, s, n, c0, got;
    int seq [2];
    int expv [2];
    int ev [2];
    logic        rq [2], wq [2];
    logic [11:0] aq [2];
    logic [3:0]  dq [2];
    i = v.inst; s = SC_TAB[i];
    rq[0] = v.r0; wq[0] = v.w0; aq[0] = v.a0; dq[0] = v.d0; ev[0] = v.e0;
    rq[1] = v.r1; wq[1] = v.w1; aq[1] = v.a1; dq[1] = v.d1; ev[1] = v.e1;
    if (rq[0] && rq[1]) begin
      n = 2;
      seq[0] = (v.exp_first >= 0) ? v.exp_first : (last_g[i] ? 0 : 1);
    end else begin
      n = 1;
      seq[0] = rq[0] ? 0 : 1;
    end
    seq[1] = 1 - seq[0];
    for (int k = 0; k < n; k++) begin
      int p;
      p = seq[k];
      expv[k] = -1;
      if (wq[p]) begin
        ref_mem[i][aq[p]] = dq[p];
        ref_valid[i][aq[p]] = 1'b1;
      end else begin
        expv[k] = (ev[p] >= 0) ? ev[p] : (ref_valid[i][aq[p]] ? int'(ref_mem[i][aq[p]]) : -1);
        exp_known[i][p] = (expv[k] >= 0);
        exp_rd[i][p] = expv[k][3:0];
      end
    end
    last_g[i] = seq[n-1][0];

    @(posedge clock); #1;
    req0[i] = rq[0]; we0[i] = wq[0]; a0[i] = aq[0]; wd0[i] = dq[0];
    req1[i] = rq[1]; we1[i] = wq[1]; a1[i] = aq[1]; wd1[i] = dq[1];
    c0 = cyc; got = 0;
    for (int t = 0; t < 2 * (s + 3) + 8 && got < n; t++) begin
      @(negedge clock);
      if (mid_addr >= 0 && cyc == c0 + 2) begin
        a0[i] = 12'(mid_addr); wd0[i] = ~dq[0];
      end
      for (int p = 0; p < 2; p++) begin
        logic a;
        a = p[0] ? ack1[i] : ack0[i];
        if (a) begin
          if (got < n && seq[got] == p) begin
            chk("ack_latency", cyc - c0, s + 2 + got * (s + 3));
            chk("grant_at_ack", grant[i], p);
            chk("ram_address_at_ack", ram_addr[i], aq[p]);
            chk("busy_during_access", busy[i], 1);
            if (!wq[p] && expv[got] >= 0) chk("read_data", p[0] ? rd1[i] : rd0[i], expv[got]);
            if (p[0]) req1[i] = 1'b0; else req0[i] = 1'b0;
            got++;
          end else chk("unexpected_ack", a, 0);
        end
      end
    end
    if (got < n) chk("ack_count_timeout", got, n);
    req0[i] = 1'b0; req1[i] = 1'b0;
    @(negedge clock);
    chk("busy_back_to_idle", busy[i], 0);
    if (exp_known[i][0]) chk("readData0_retained", rd0[i], exp_rd[i][0]);
    if (exp_known[i][1]) chk("readData1_retained", rd1[i], exp_rd[i][1]);
  endtask

  // Both ports keep req high through n accesses: port 0 reads 0x123, port 1 reads 0xFFF.
  task automatic b2b(input int i, input int n);
    int s, c0, got, p;
    int ev [2];
    logic [11:0] aq [2];
    s = SC_TAB[i]; aq[0] = 12'h123; aq[1] = 12'hFFF;
    for (int q = 0; q < 2; q++) ev[q] = ref_valid[i][aq[q]] ? int'(ref_mem[i][aq[q]]) : -1;
    @(posedge clock); #1;
    req0[i] = 1'b1; we0[i] = 1'b0; a0[i] = aq[0]; wd0[i] = 4'h5;
    req1[i] = 1'b1; we1[i] = 1'b0; a1[i] = aq[1]; wd1[i] = 4'hC;
    c0 = cyc; got = 0;
    p = last_g[i] ? 0 : 1;
    for (int t = 0; t < n * (s + 3) + 10 && got < n; t++) begin
      @(negedge clock);
      if (ack0[i] || ack1[i]) begin
        chk("b2b_grant", grant[i], p);
        chk("b2b_ack_port", ack1[i], p);
        chk("b2b_latency", cyc - c0, s + 2 + got * (s + 3));
        if (ev[p] >= 0) begin
          chk("b2b_read_data", p[0] ? rd1[i] : rd0[i], ev[p]);
          exp_rd[i][p] = ev[p][3:0]; exp_known[i][p] = 1'b1;
        end
        if (exp_known[i][1-p]) chk("b2b_other_readdata", p[0] ? rd0[i] : rd1[i], exp_rd[i][1-p]);
        last_g[i] = p[0];
        p = 1 - p;
        got++;
        if (got == n) begin req0[i] = 1'b0; req1[i] = 1'b0; end
      end
    end
    if (got < n) chk("b2b_ack_timeout", got, n);
    req0[i] = 1'b0; req1[i] = 1'b0;
    @(negedge clock);
    chk("b2b_idle", busy[i], 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      last_g[i] = 1'b1;
      for (int p = 0; p < 2; p++) begin exp_rd[i][p] = 4'h0; exp_known[i][p] = 1'b1; end
    end
  endtask

  initial begin
    vec_t tbl [12];
    vec_t v;
    int   m;
    bit   seen;
    notReset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req0[i] = 0; we0[i] = 0; a0[i] = 0; wd0[i] = 0;
      req1[i] = 0; we1[i] = 0; a1[i] = 0; wd1[i] = 0;
      for (int j = 0; j < 4096; j++) ref_valid[i][j] = 1'b0;
    end
    model_reset();

    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset_nce", nce[i], 1);
      chk("reset_nwe", nwe[i], 1);
      chk("reset_addr", ram_addr[i], 0);
      chk("reset_acks", {ack1[i], ack0[i]}, 0);
      chk("reset_readdata", {rd1[i], rd0[i]}, 0);
      chk("reset_busy", busy[i], 0);
      chk("reset_grant", grant[i], 0);
    end
    @(negedge clock);
    notReset = 1'b1;

    tbl[0]  = mk(0, 1, 1, 'h010, 'h5, 1, 1, 'h020, 'h9, 0, -1, -1);
    tbl[1]  = mk(0, 1, 1, 'h123, 'hA, 0, 0, 0, 0, 0, -1, -1);
    tbl[2]  = mk(0, 1, 0, 'h123, 'h5, 0, 0, 0, 0, 0, 'hA, -1);
    tbl[3]  = mk(0, 1, 0, 'h010, 'hC, 1, 0, 'h020, 'h3, 1, 'h5, 'h9);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 1, 'hFFF, 'h3, 1, -1, -1);
    tbl[5]  = mk(0, 1, 1, 'h008, 'h2, 0, 0, 0, 0, 0, -1, -1);
    tbl[6]  = mk(1, 1, 1, 'h800, 'h6, 0, 0, 0, 0, 0, -1, -1);
    tbl[7]  = mk(1, 1, 0, 'h800, 'h9, 0, 0, 0, 0, 0, 'h6, -1);
    tbl[8]  = mk(2, 1, 1, 'h800, 'h6, 0, 0, 0, 0, 0, -1, -1);
    tbl[9]  = mk(2, 1, 0, 'h800, 'h9, 0, 0, 0, 0, 0, 'h6, -1);
    tbl[10] = mk(0, 1, 1, 'hFFE, 'h1, 1, 1, 'h000, 'hC, 1, -1, -1);
    tbl[11] = mk(0, 1, 0, 'h000, 'h0, 1, 0, 'hFFE, 'h0, 1, 'hC, 'h1);
    for (int r = 0; r < 12; r++) do_round(tbl[r], -1);

    b2b(0, 6);

    do_round(mk(0, 1, 1, 'h004, 'h7, 0, 0, 0, 0, 0, -1, -1), 'h008);
    do_round(mk(0, 1, 0, 'h004, 'h0, 1, 0, 'h008, 'h0, -1, 'h7, 'h2), -1);

    for (int r = 0; r < 40; r++) begin
      v.inst = int'($urandom_range(0, 2));
      m = int'($urandom_range(1, 3));
      v.r0 = m[0]; v.w0 = 1'($urandom_range(0, 1)); v.a0 = pick_addr(); v.d0 = 4'($urandom);
      v.r1 = m[1]; v.w1 = 1'($urandom_range(0, 1)); v.a1 = pick_addr(); v.d1 = 4'($urandom);
      v.exp_first = -1; v.e0 = -1; v.e1 = -1;
      do_round(v, -1);
    end

    // Reset in the middle of a write strobe.
    @(posedge clock); #1;
    req0[0] = 1'b1; we0[0] = 1'b1; a0[0] = 12'h001; wd0[0] = 4'hF;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clock);
      if (!nce[0]) seen = 1'b1;
    end
    chk("strobe_reached_before_reset", seen, 1);
    #2;
    notReset = 1'b0; req0[0] = 1'b0;
    #1;
    chk("midreset_nce", nce[0], 1);
    chk("midreset_nwe", nwe[0], 1);
    chk("midreset_ack", ack0[0], 0);
    chk("midreset_busy", busy[0], 0);
    chk("midreset_readdata", rd0[0], 0);
    @(negedge clock);
    chk("midreset_no_late_ack", ack0[0], 0);
    notReset = 1'b1;
    model_reset();
    ref_valid[0][1] = 1'b0;

    do_round(mk(0, 1, 1, 'h001, 'h4, 1, 0, 'hFFF, 'h0, 0, -1, -1), -1);
    do_round(mk(0, 1, 0, 'h001, 'h0, 0, 0, 0, 0, 0, 'h4, -1), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
